// File: rtl/ova_pkg.sv
// Shared constants for the camera pooling path: RGB565 fields, gray weights, frame defaults.
// Combinational helpers only; no latency, no flow control.
package ova_pkg;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    localparam logic [15:0] COEF_R = 16'd77;
    localparam logic [15:0] COEF_G = 16'd150;
    localparam logic [15:0] COEF_B = 16'd29;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_IN_FRAME,
        FS_COMPLETE
    } frame_state_e;

    // Weights sum to 256, so the 16-bit accumulator cannot overflow for 8-bit channels.
    function automatic logic [7:0] rgb565_to_gray(input logic [15:0] pix);
        logic [4:0]  r5;
        logic [5:0]  g6;
        logic [4:0]  b5;
        logic [15:0] r8;
        logic [15:0] g8;
        logic [15:0] b8;
        logic [15:0] acc;
        r5  = pix[R_MSB:R_LSB];
        g6  = pix[G_MSB:G_LSB];
        b5  = pix[B_MSB:B_LSB];
        r8  = {8'd0, r5, r5[4:2]};
        g8  = {8'd0, g6, g6[5:4]};
        b8  = {8'd0, b5, b5[4:2]};
        acc = COEF_R * r8 + COEF_G * g8 + COEF_B * b8;
        return 8'(acc >> 8);
    endfunction

endpackage

// File: rtl/pool_line_ram.sv
// Half-line buffer: one write port, one registered read port, array not reset.
// Read data appears one clk after rd_en_i and holds until the next read; no backpressure.
module pool_line_ram #(
    parameter int DEPTH = 320,
    parameter int WIDTH = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_en_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_dat_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/ova_pix_pool.sv
// RGB565 -> gray -> 2x2 average pool, quarter-resolution output stream.
// Latency 3 clk from the window's last pixel to o_pix_vld; no backpressure, gaps on input allowed.
module ova_pix_pool
    import ova_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_sof,
    input  logic [15:0] i_data,
    input  logic        i_data_vld,
    output logic [7:0]  o_pix,
    output logic        o_pix_vld,
    output logic        o_frame_done,
    output logic        o_frame_err
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int AW = $clog2(IMG_W / 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    frame_state_e  state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          frame_err_q;

    logic          accept;
    logic [CW-1:0] pcol;
    logic [RW-1:0] prow;
    logic          pix_last;

    // A pixel coincident with i_sof belongs to the new frame at (0,0).
    assign accept   = i_data_vld && (i_sof || state_q == FS_IN_FRAME);
    assign pcol     = i_sof ? '0 : col_q;
    assign prow     = i_sof ? '0 : row_q;
    assign pix_last = (pcol == COL_LAST) && (prow == ROW_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FS_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= i_sof && (state_q == FS_IN_FRAME);
            if (i_sof) begin
                state_q <= FS_IN_FRAME;
                col_q   <= '0;
                row_q   <= '0;
            end
            if (accept) begin
                if (pix_last) begin
                    state_q <= FS_COMPLETE;
                    col_q   <= '0;
                    row_q   <= '0;
                end else if (pcol == COL_LAST) begin
                    col_q <= '0;
                    row_q <= prow + RW'(1);
                end else begin
                    col_q <= pcol + CW'(1);
                    row_q <= prow;
                end
            end
        end
    end

    // Stage 0: captured pixel and its position.
    logic          s0_vld_q;
    logic [15:0]   s0_dat_q;
    logic [CW-1:0] s0_col_q;
    logic          s0_row_odd_q;
    logic          s0_last_q;
    // Stage 1: gray value.
    logic          s1_vld_q;
    logic [7:0]    s1_y_q;
    logic          s1_col_odd_q;
    logic          s1_row_odd_q;
    logic [AW-1:0] s1_addr_q;
    logic          s1_last_q;
    // Stage 2: horizontal pair sum for odd rows.
    logic [7:0]    yeven_q;
    logic          s2_vld_q;
    logic [8:0]    s2_h_q;
    logic          s2_last_q;
    // Stage 3: outputs.
    logic [7:0]    o_pix_q;
    logic          o_pix_vld_q;
    logic          o_frame_done_q;

    logic [8:0]    h_d;
    logic [9:0]    sum_d;
    logic [8:0]    ram_rd_dat;
    logic          ram_wr_en;
    logic          ram_rd_en;

    assign h_d       = {1'b0, yeven_q} + {1'b0, s1_y_q};
    assign sum_d     = {1'b0, ram_rd_dat} + {1'b0, s2_h_q};
    assign ram_wr_en = s1_vld_q && s1_col_odd_q && !s1_row_odd_q;
    // Read at the even column of an odd row; data stays put until the next even column.
    assign ram_rd_en = s1_vld_q && !s1_col_odd_q && s1_row_odd_q;

    pool_line_ram #(
        .DEPTH (IMG_W / 2),
        .WIDTH (9),
        .AW    (AW)
    ) u_line_ram (
        .clk       (clk),
        .wr_en_i   (ram_wr_en),
        .wr_addr_i (s1_addr_q),
        .wr_dat_i  (h_d),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (s1_addr_q),
        .rd_dat_o  (ram_rd_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld_q       <= 1'b0;
            s0_dat_q       <= '0;
            s0_col_q       <= '0;
            s0_row_odd_q   <= 1'b0;
            s0_last_q      <= 1'b0;
            s1_vld_q       <= 1'b0;
            s1_y_q         <= '0;
            s1_col_odd_q   <= 1'b0;
            s1_row_odd_q   <= 1'b0;
            s1_addr_q      <= '0;
            s1_last_q      <= 1'b0;
            yeven_q        <= '0;
            s2_vld_q       <= 1'b0;
            s2_h_q         <= '0;
            s2_last_q      <= 1'b0;
            o_pix_q        <= '0;
            o_pix_vld_q    <= 1'b0;
            o_frame_done_q <= 1'b0;
        end else begin
            s0_vld_q <= accept;
            if (accept) begin
                s0_dat_q     <= i_data;
                s0_col_q     <= pcol;
                s0_row_odd_q <= prow[0];
                s0_last_q    <= pix_last;
            end

            s1_vld_q <= s0_vld_q && !i_sof;
            if (s0_vld_q) begin
                s1_y_q       <= rgb565_to_gray(s0_dat_q);
                s1_col_odd_q <= s0_col_q[0];
                s1_row_odd_q <= s0_row_odd_q;
                s1_addr_q    <= AW'(s0_col_q >> 1);
                s1_last_q    <= s0_last_q;
            end

            if (s1_vld_q && !s1_col_odd_q) begin
                yeven_q <= s1_y_q;
            end
            s2_vld_q <= s1_vld_q && s1_col_odd_q && s1_row_odd_q && !i_sof;
            if (s1_vld_q && s1_col_odd_q) begin
                s2_h_q    <= h_d;
                s2_last_q <= s1_last_q;
            end

            o_pix_vld_q    <= s2_vld_q && !i_sof;
            o_frame_done_q <= s2_vld_q && s2_last_q && !i_sof;
            if (s2_vld_q) begin
                o_pix_q <= 8'(sum_d >> 2);
            end
        end
    end

    assign o_pix        = o_pix_q;
    assign o_pix_vld    = o_pix_vld_q;
    assign o_frame_done = o_frame_done_q;
    assign o_frame_err  = frame_err_q;

endmodule

// File: tb/tb_ova_pix_pool.sv
// Randomized bench for ova_pix_pool at 4x4, checked against a pixel-array pooling model.
module tb_ova_pix_pool;

    localparam int W    = 4;
    localparam int H    = 4;
    localparam int NPIX = W * H;
    localparam int NOUT = (W / 2) * (H / 2);

    logic        clk = 1'b0;
    logic        rst;
    logic        i_sof;
    logic [15:0] i_data;
    logic        i_data_vld;
    logic [7:0]  o_pix;
    logic        o_pix_vld;
    logic        o_frame_done;
    logic        o_frame_err;

    always #5 clk = ~clk;

    ova_pix_pool #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_sof        (i_sof),
        .i_data       (i_data),
        .i_data_vld   (i_data_vld),
        .o_pix        (o_pix),
        .o_pix_vld    (o_pix_vld),
        .o_frame_done (o_frame_done),
        .o_frame_err  (o_frame_err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int edge_n = 0;
    int stray_done = 0;

    int obs_pix[$];
    int obs_done[$];
    int obs_edge[$];
    int err_edge[$];

    logic [15:0] frm [NPIX];

    always @(posedge clk) edge_n <= edge_n + 1;

    always @(negedge clk) begin
        if (o_pix_vld) begin
            obs_pix.push_back(int'(o_pix));
            obs_done.push_back(int'(o_frame_done));
            obs_edge.push_back(edge_n);
        end else if (o_frame_done) begin
            stray_done++;
        end
        if (o_frame_err) err_edge.push_back(edge_n);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int gray_ref(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        return (77 * r + 150 * g + 29 * b) / 256;
    endfunction

    task automatic clear_obs();
        obs_pix.delete();
        obs_done.delete();
        obs_edge.delete();
        err_edge.delete();
    endtask

    task automatic step(input logic sof, input logic vld, input logic [15:0] d);
        i_sof      = sof;
        i_data_vld = vld;
        i_data     = d;
        @(posedge clk);
        #1;
        i_sof      = 1'b0;
        i_data_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 16'($urandom));
    endtask

    // with_first: i_sof rides on pixel 0, otherwise a separate i_sof cycle precedes the frame.
    task automatic drive_frame(input bit with_first, input bit gaps,
                               output int sof_edge, output int win_edge);
        sof_edge = -1;
        win_edge = -1;
        if (!with_first) begin
            step(1'b1, 1'b0, 16'h0);
            sof_edge = edge_n;
        end
        for (int i = 0; i < NPIX; i++) begin
            if (gaps) idle($urandom_range(0, 2));
            step(with_first && (i == 0), 1'b1, frm[i]);
            if (with_first && i == 0) sof_edge = edge_n;
            if (i == W + 1) win_edge = edge_n;
        end
        idle(4);
    endtask

    task automatic check_frame(input string tag);
        int k;
        int s;
        chk({tag, "_count"}, obs_pix.size(), NOUT);
        for (int r = 0; r < H / 2; r++) begin
            for (int c = 0; c < W / 2; c++) begin
                k = r * (W / 2) + c;
                s = gray_ref(frm[2*r*W + 2*c])     + gray_ref(frm[2*r*W + 2*c + 1])
                  + gray_ref(frm[(2*r+1)*W + 2*c]) + gray_ref(frm[(2*r+1)*W + 2*c + 1]);
                if (k < obs_pix.size()) begin
                    chk($sformatf("%s_pix%0d", tag, k), obs_pix[k], s / 4);
                    chk($sformatf("%s_done%0d", tag, k), obs_done[k], int'(k == NOUT - 1));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int se;
        int we;
        bit seen;
        rst        = 1'b1;
        i_sof      = 1'b0;
        i_data     = 16'h0;
        i_data_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pix", int'(o_pix), 0);
        chk("rst_vld", int'(o_pix_vld), 0);
        chk("rst_done", int'(o_frame_done), 0);
        chk("rst_err", int'(o_frame_err), 0);
        rst = 1'b0;
        idle(2);

        // Pixels before the first i_sof are dropped.
        clear_obs();
        for (int i = 0; i < NPIX; i++) step(1'b0, 1'b1, 16'($urandom));
        idle(4);
        chk("presof_count", obs_pix.size(), 0);

        clear_obs();
        for (int i = 0; i < NPIX; i++) frm[i] = 16'hFFFF;
        drive_frame(1'b0, 1'b0, se, we);
        check_frame("white");
        if (obs_pix.size() > 3) chk("white_val", obs_pix[3], 255);
        chk("white_err", err_edge.size(), 0);

        clear_obs();
        for (int i = 0; i < NPIX; i++) frm[i] = 16'hF800;
        drive_frame(1'b0, 1'b0, se, we);
        check_frame("red");
        if (obs_pix.size() > 0) chk("red_val", obs_pix[0], 76);
        chk("red_latency", (obs_edge.size() > 0) ? obs_edge[0] - we : -1, 3);

        clear_obs();
        for (int i = 0; i < NPIX; i++) frm[i] = (((i / W) + (i % W)) % 2 == 0) ? 16'hFFFF : 16'h0000;
        drive_frame(1'b0, 1'b0, se, we);
        check_frame("mixed");
        if (obs_pix.size() > 0) chk("mixed_val", obs_pix[0], 127);

        // Ramp frame without and with input gaps.
        for (int g = 0; g < 2; g++) begin
            clear_obs();
            for (int i = 0; i < NPIX; i++) frm[i] = 16'(i * 16'h1111 + 16'h0842);
            drive_frame(1'b0, g[0], se, we);
            check_frame(g == 0 ? "ramp" : "ramp_gap");
            chk("ramp_err", err_edge.size(), 0);
        end

        // Random frames back to back, random i_sof placement and gaps.
        for (int f = 0; f < 4; f++) begin
            clear_obs();
            for (int i = 0; i < NPIX; i++) frm[i] = 16'($urandom);
            drive_frame(1'($urandom), 1'($urandom), se, we);
            check_frame($sformatf("rand%0d", f));
            chk($sformatf("rand%0d_err", f), err_edge.size(), 0);
        end

        // Frame aborted after 6 pixels; the next i_sof carries pixel 0 of a new frame.
        clear_obs();
        step(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'($urandom));
        for (int i = 0; i < NPIX; i++) frm[i] = 16'($urandom);
        drive_frame(1'b1, 1'b0, se, we);
        check_frame("abort");
        chk("abort_err_count", err_edge.size(), 1);
        if (err_edge.size() > 0) chk("abort_err_edge", err_edge[0], se);

        // Asynchronous reset while a pooled pixel is on the output.
        clear_obs();
        step(1'b1, 1'b0, 16'h0);
        for (int i = 0; i < NPIX; i++) frm[i] = 16'($urandom) | 16'h8000;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, frm[i]);
        seen = 1'b0;
        for (int t = 0; t < 5 && !seen; t++) begin
            if (o_pix_vld) seen = 1'b1;
            else step(1'b0, 1'b0, 16'h0);
        end
        chk("rst_mid_vld_before", int'(seen), 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_vld", int'(o_pix_vld), 0);
        chk("rst_mid_pix", int'(o_pix), 0);
        chk("rst_mid_done", int'(o_frame_done), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_obs();
        for (int i = 0; i < NPIX; i++) step(1'b0, 1'b1, 16'($urandom));
        idle(4);
        chk("postrst_ignored", obs_pix.size(), 0);
        clear_obs();
        for (int i = 0; i < NPIX; i++) frm[i] = 16'($urandom);
        drive_frame(1'b0, 1'b1, se, we);
        check_frame("postrst");
        chk("postrst_err", err_edge.size(), 0);

        chk("stray_done", stray_done, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ova_pix_pool.md
# ova_pix_pool

Downstream stage of the camera capture path. Consumes the 16-bit RGB565 pixel stream produced by the camera reader after it has crossed into the system clock domain through the capture FIFO. Converts each pixel to 8-bit grayscale and applies 2x2 average pooling using a half-width line buffer. Emits a quarter-resolution grayscale stream that feeds the CNN input buffer.

## Interface
Parameters:
- IMG_W, 640, input pixels per line (even, ≥4)
- IMG_H, 480, input lines per frame (even, ≥2)

Ports:
- clk  in  1  system clock (50 MHz); one clock, all logic on the rising edge
- rst  in  1  reset, asynchronous and active-high
- i_sof  in  1  one-cycle frame-start pulse
- i_data  in  16  RGB565 pixel: [15:11] R, [10:5] G, [4:0] B
- i_data_vld  in  1  i_data valid this cycle; no backpressure
- o_pix  out  8  pooled grayscale pixel
- o_pix_vld  out  1  o_pix valid, one cycle per pooled pixel
- o_frame_done  out  1  pulse coincident with the last pooled pixel of a frame
- o_frame_err  out  1  pulse: i_sof arrived before the current frame was complete

## Operation
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 advance on each accepted pixel. col wraps to 0 and increments row.
- After the last pixel of the frame (row IMG_H-1, col IMG_W-1), further pixels are ignored until the next i_sof.
- Before the first i_sof after reset, all pixels are ignored.
- Gray conversion, stage 1:
  - Expand channels: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}.
  - Y = (77·R8 + 150·G8 + 29·B8) >> 8, using a 16-bit unsigned sum; no overflow.
- Horizontal pair, stage 2:
  - Even column: hold Y.
  - Odd column: h = Yeven + Yodd, 9 bits.
- Vertical, stage 3:
  - Even row: write h to line RAM at address col>>1.
  - Odd row: s = RAM[col>>1] + h (10 bits); o_pix = s[9:2] (truncate, no rounding).
  - The RAM read is issued at the even column so data is ready at the odd column.
- The line RAM holds IMG_W/2 entries × 9 bits. Contents are never cleared; every entry is written before it is read.
- i_sof:
  - Zeroes col and row and squashes all in-flight pipeline valids. No output from the old frame appears afterwards.
  - If the previous frame had started but was not complete, o_frame_err pulses.
- i_sof together with i_data_vld in the same cycle: the pixel is col 0, row 0 of the new frame.
- Gaps in i_data_vld are allowed at any point; the pipeline holds state and only advances on valid.

## Timing
- Reset values: o_pix=0, o_pix_vld=0, o_frame_done=0, o_frame_err=0, counters 0, pipeline valids 0, armed flag 0.
- Latency: the pixel at odd row / odd column sampled at edge N produces o_pix_vld high after edge N+3, i.e. 3 clk. The latency is fixed regardless of input gaps once the window's last pixel arrives.
- o_frame_done is high in the same cycle as o_pix_vld for pooled pixel (IMG_H/2-1, IMG_W/2-1).
- o_frame_err is registered and asserts the cycle after the offending i_sof.
- Output throughput: at most one pooled pixel per two input pixels. Over a frame, there are (IMG_W/2)·(IMG_H/2) o_pix_vld pulses.
- Asynchronous assertion of rst mid-frame clears everything immediately. After deassertion, the block waits for i_sof.

## Structure
- Shared package `ova_pkg`:
  - RGB565 field positions
  - gray coefficients 77/150/29
  - default IMG_W/IMG_H
- Sub-module `pool_line_ram`: simple dual-port, 1 write + 1 registered read. Depth IMG_W/2, width 9, no reset on the array.
- Top level: counters, 3-stage pipeline, frame-state logic, with flags idle / in_frame / frame_complete.

## Test plan
Run with IMG_W=4, IMG_H=4 unless noted.
- Uniform white: i_sof, then 16 × 0xFFFF back-to-back → 4 pulses of o_pix=0xFF; o_frame_done with the 4th; o_frame_err stays 0.
- Pure red: 16 × 0xF800 → 4 × o_pix=76 (0x4C); first o_pix_vld 3 clk after pixel (1,1).
- Mixed window: row 0 = 0xFFFF,0x0000,…; row 1 = 0x0000,0xFFFF,… → 2x2 sum 510 → o_pix=127 for the applicable windows.
- Random valid gaps (~50% duty) on the ramp frame → identical o_pix sequence to the gap-free run.
- i_sof after 6 pixels → o_frame_err pulse, no stale outputs. The following full frame pools correctly.
- Simultaneous i_sof+i_data_vld, back-to-back frames, and rst asserted mid-frame → each case pools from col 0 / row 0. After rst, pixels are ignored until i_sof.
